uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, system clock frequency in Hz SHALL be provided.
REQ-002 Parameter BIT_RATE, 115_200, serial bit rate in baud SHALL be provided.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rx_data  output  8  received byte, valid while rx_valid high.
REQ-007 rx_valid  output  1  byte available; held until accepted.
REQ-008 rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready.
REQ-009 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 overrun  output  1  one-cycle pulse when a completed byte is dropped for lack of storage.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 rx SHALL pass a 2-flop synchronizer before use; only the synchronized value drives the FSM.
REQ-013 BIT_CYCLES = CLK_HZ/BIT_RATE (integer division, 434 at defaults); HALF_CYCLES = BIT_CYCLES/2 (217); counter width $clog2(BIT_CYCLES).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: synced rx = 0 -> START, counter cleared.
REQ-016 START: after HALF_CYCLES cycles sample; 1 -> IDLE (glitch rejected, no error flag); 0 -> DATA, counter and bit index cleared.
REQ-017 DATA: every BIT_CYCLES cycles sample one bit into bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-018 STOP: after BIT_CYCLES cycles sample; 1 -> byte pushed to storage, -> IDLE; 0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until synced rx = 1, then -> IDLE (break conditions produce exactly one frame_err).
REQ-020 rx_valid SHALL assert the cycle after the good stop-bit sample; rx_data SHALL stay stable while rx_valid && !rx_ready.
REQ-021 Push into full storage SHALL drop the new byte, pulse overrun, and preserve stored data.
REQ-022 Push and pop in the same cycle with full storage SHALL accept the new byte without overrun.
REQ-023 Back-to-back frames (stop bit directly followed by start bit) SHALL be received without loss.

Reset
REQ-024 rst SHALL force state IDLE, counters 0, synchronizer flops 1, storage empty, rx_data 0x00, rx_valid/frame_err/overrun/busy 0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no flag output; reception resumes at the next falling edge after release.

Configuration
REQ-026 Macro UART_RX_FIFO_EN defined: storage SHALL be an RX_FIFO_DEPTH (8) entry FIFO, rx_data showing the head entry; overrun only when 8 entries held.
REQ-027 Macro UART_RX_FIFO_EN undefined: storage SHALL be a single holding register; port list and handshake identical.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum typedef, DATA_BITS = 8 and RX_FIFO_DEPTH = 8.
REQ-029 Sub-module uart_rx_fifo (synchronous FIFO, push/pop/full/empty) SHALL be instantiated only under UART_RX_FIFO_EN.

Verification
REQ-030 Frame 0xA5, rx_ready=1 -> rx_valid high one cycle with rx_data=0xA5, frame_err=overrun=0.
REQ-031 100-cycle low glitch on idle rx -> busy returns 0 after START sample, no rx_valid, no frame_err.
REQ-032 Frame 0x3C with stop bit 0, rx held low 2000 cycles, then frame 0x55 -> one frame_err pulse, no valid for 0x3C, 0x55 delivered.
REQ-033 rx_ready=0, frames 0x11 then 0x22 (no FIFO) -> rx_data stays 0x11, overrun pulse at second stop; with FIFO, 9 frames -> first 8 delivered in order, overrun on 9th.
REQ-034 rst pulsed mid-DATA of 0xF0, then frame 0x0F -> all outputs at reset values, then 0x0F delivered correctly.
REQ-035 Back-to-back frames 0x00, 0xFF with rx_ready=1 -> both delivered, no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
`timescale 1ns/1ps
package uart_pkg;
  localparam int DATA_BITS     = 8;
  localparam int RX_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; head entry is always on rdata.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop)
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a ready/valid byte output.
// Define UART_RX_FIFO_EN to buffer bytes in an RX_FIFO_DEPTH FIFO instead of
// a single holding register.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 115_200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int BIT_CYCLES  = CLK_HZ / BIT_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES);
  localparam int BIDX_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [1:0]           sync_vld_q, sync_vld_d;
  logic                 armed_q, armed_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 stop_tick, push, pop;

  // Synchronizer inputs; armed tracks a genuinely observed high line so that
  // the reset value of the synchronizer never looks like a falling edge.
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = sync_vld_q[1] && rx_sync_q;
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      sync_vld_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      sync_vld_q <= sync_vld_d;
      armed_q    <= armed_d;
    end
  end

  // FSM and datapath state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next state: mid-bit sampling driven by the cycle counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (armed_q && !rx_sync_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BIDX_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? ST_IDLE : ST_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: push on a good stop bit, error on a bad one
  always_comb begin
    stop_tick   = (state_q == ST_STOP) && (cnt_q == BIT_LAST);
    push        = stop_tick && rx_sync_q;
    frame_err_d = stop_tick && !rx_sync_q;
    busy        = (state_q != ST_IDLE);
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Overrun only when full and no slot frees up this cycle
  always_comb begin
    pop       = !fifo_empty && rx_ready;
    overrun_d = push && fifo_full && !pop;
  end

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_rdata;
`else
  logic                 hold_vld_q, hold_vld_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;

  // Single holding register; a same-cycle pop frees it for the new byte
  always_comb begin
    pop         = hold_vld_q && rx_ready;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    overrun_d   = 1'b0;
    if (pop) hold_vld_d = 1'b0;
    if (push) begin
      if (!hold_vld_q || pop) begin
        hold_vld_d  = 1'b1;
        hold_data_d = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Holding register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign rx_valid = hold_vld_q;
  assign rx_data  = hold_data_q;
`endif

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default clock/baud settings.
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int CLK_HZ   = 50_000_000;
  localparam int BIT_RATE = 115_200;
  localparam int BIT      = CLK_HZ / BIT_RATE;
  localparam int HALF     = BIT / 2;

  logic       clk = 1'b0;
  logic       rst, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int tests = 0, fails = 0;
  logic [7:0] got[$];
  int vcyc = 0, fe_cnt = 0, ov_cnt = 0;
  int n0, v0, f0, o0;

  always #5 clk = ~clk;

  uart_receiver #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Observe handshakes and flag pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid)  vcyc++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bitt(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    bitt(1'b0);
    for (int i = 0; i < 8; i++) bitt(b[i]);
    bitt(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic snap();
    n0 = got.size(); v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clk); rst = 1'b0;
    idle(20);

    // Single frame, consumer ready
    snap();
    send(8'hA5, 1'b1); idle(20); @(negedge clk);
    chk("a5_count", got.size() - n0, 1);
    chk("a5_data", got[n0], 8'hA5);
    chk("a5_vcyc", vcyc - v0, 1);
    chk("a5_ferr", fe_cnt - f0, 0);
    chk("a5_ovr", ov_cnt - o0, 0);

    // Short low glitch on idle line
    snap();
    rx = 1'b0; repeat (100) @(posedge clk);
    rx = 1'b1; repeat (20) @(posedge clk); @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (HALF) @(posedge clk); @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_novalid", vcyc - v0, 0);
    chk("glitch_noferr", fe_cnt - f0, 0);

    // Bad stop bit plus long break, then a good frame
    snap();
    send(8'h3C, 1'b0);
    rx = 1'b0; repeat (2000) @(posedge clk);
    idle(50);
    send(8'h55, 1'b1); idle(20); @(negedge clk);
    chk("brk_ferr", fe_cnt - f0, 1);
    chk("brk_count", got.size() - n0, 1);
    chk("brk_data", got[n0], 8'h55);
    chk("brk_busy", busy, 0);

    // Overrun with consumer stalled
    snap();
    rx_ready = 1'b0;
`ifdef UART_RX_FIFO_EN
    for (int k = 0; k < 9; k++) send(8'h11 + 8'(k), 1'b1);
    idle(20); @(negedge clk);
    chk("ovr_pulse", ov_cnt - o0, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_head", rx_data, 8'h11);
    rx_ready = 1'b1;
    repeat (20) @(posedge clk); @(negedge clk);
    chk("ovr_count", got.size() - n0, 8);
    for (int k = 0; k < 8; k++) chk("ovr_order", got[n0 + k], 8'h11 + 8'(k));
    chk("ovr_drained", rx_valid, 0);
`else
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    idle(20); @(negedge clk);
    chk("ovr_pulse", ov_cnt - o0, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_hold", rx_data, 8'h11);
    chk("ovr_nopop", got.size() - n0, 0);
    rx_ready = 1'b1;
    repeat (5) @(posedge clk); @(negedge clk);
    chk("ovr_count", got.size() - n0, 1);
    chk("ovr_first", got[n0], 8'h11);
    chk("ovr_drained", rx_valid, 0);
`endif

    // Reset in the middle of a 0xF0 frame while the line is low
    snap();
    bitt(1'b0); bitt(1'b0); bitt(1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk); @(negedge clk);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    @(posedge clk); rst = 1'b0;
    bitt(1'b0);
    for (int i = 0; i < 5; i++) bitt(1'b1);
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_noferr", fe_cnt - f0, 0);
    chk("post_rst_novalid", got.size() - n0, 0);
    idle(50);
    send(8'h0F, 1'b1); idle(20); @(negedge clk);
    chk("post_rst_count", got.size() - n0, 1);
    chk("post_rst_data", got[n0], 8'h0F);

    // Back-to-back frames
    snap();
    send(8'h00, 1'b1); send(8'hFF, 1'b1); idle(20); @(negedge clk);
    chk("b2b_count", got.size() - n0, 2);
    chk("b2b_first", got[n0], 8'h00);
    chk("b2b_second", got[n0 + 1], 8'hFF);
    chk("b2b_ferr", fe_cnt - f0, 0);
    chk("b2b_ovr", ov_cnt - o0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
